// File: rtl/dpu_result_packer.sv
// dpu_result_packer
//
// Collects WORD_BITWIDTH-bit DPU results and packs them, lane 0 first, into
// BULK_BITWIDTH-bit bulk words. A one-entry output register decouples the
// producer from the consumer. The words-per-bulk target is configurable, and
// a flush emits whatever partial bulk has been collected.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cfg_valid, cfg_words  load a new words-per-bulk target (0 or >WORDS -> WORDS)
//   flush                 emit the current partial bulk
//   word_valid/word_ready/word_data   producer side
//   bulk_valid/bulk_ready/bulk_data/bulk_count   consumer side
//   busy                  pack non-empty, held bulk pending, or output valid
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A valid never waits on ready. The output register holds its value
// while bulk_valid && !bulk_ready. word_ready does not depend on word_valid.

module dpu_result_packer #(
  parameter int WORD_BITWIDTH = 16,
  parameter int BULK_BITWIDTH = 256,
  localparam int WORDS = BULK_BITWIDTH / WORD_BITWIDTH,
  localparam int CW = $clog2(WORDS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [CW-1:0]            cfg_words,
  input  logic                     flush,
  input  logic                     word_valid,
  input  logic [WORD_BITWIDTH-1:0] word_data,
  output logic                     word_ready,
  output logic                     bulk_valid,
  output logic [BULK_BITWIDTH-1:0] bulk_data,
  output logic [CW-1:0]            bulk_count,
  input  logic                     bulk_ready,
  output logic                     busy
);

  logic [WORDS-1:0][WORD_BITWIDTH-1:0] pack_q;
  logic [WORDS-1:0][WORD_BITWIDTH-1:0] out_q;
  logic [WORDS-1:0][WORD_BITWIDTH-1:0] merged;
  logic [CW-1:0] count_q;
  logic [CW-1:0] held_count_q;
  logic [CW-1:0] target_q;
  logic [CW-1:0] out_count_q;
  logic          full_q;
  logic          valid_q;

  logic          accept;
  logic          out_free;
  logic [CW-1:0] fill;
  logic          complete;
  logic          flush_fire;
  logic          emit;
  logic          cfg_take;
  logic [CW-1:0] cfg_target;

  assign accept     = word_valid && !full_q;
  assign out_free   = !valid_q || bulk_ready;
  // Lanes filled once this cycle's word (if any) is included.
  assign fill       = count_q + {{(CW-1){1'b0}}, accept};
  assign complete   = accept && (fill == target_q);
  assign flush_fire = flush && !full_q && ((count_q != '0) || accept);
  assign emit       = complete || flush_fire;
  // A target change only applies between bulks, so a bulk in progress is
  // always finished with the target it started with.
  assign cfg_take   = cfg_valid && (count_q == '0) && !full_q && !accept;
  assign cfg_target = ((cfg_words == '0) || (cfg_words > CW'(WORDS))) ?
                      CW'(WORDS) : cfg_words;

  // Pack lanes with the incoming word merged in and every lane at or beyond
  // the fill level forced to zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (accept && (count_q == CW'(i))) begin
        merged[i] = word_data;
      end else begin
        merged[i] = pack_q[i];
      end
      if (CW'(i) >= fill) begin
        merged[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q       <= '0;
      out_q        <= '0;
      count_q      <= '0;
      held_count_q <= '0;
      target_q     <= CW'(WORDS);
      out_count_q  <= '0;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      if (full_q) begin
        // A finished bulk is parked in the pack; move it out as soon as the
        // output register can take it.
        if (out_free) begin
          out_q        <= pack_q;
          out_count_q  <= held_count_q;
          valid_q      <= 1'b1;
          full_q       <= 1'b0;
          pack_q       <= '0;
          held_count_q <= '0;
        end
      end else if (emit) begin
        count_q <= '0;
        if (out_free) begin
          out_q       <= merged;
          out_count_q <= fill;
          valid_q     <= 1'b1;
          pack_q      <= '0;
        end else begin
          full_q       <= 1'b1;
          pack_q       <= merged;
          held_count_q <= fill;
        end
      end else begin
        if (valid_q && bulk_ready) begin
          valid_q <= 1'b0;
        end
        if (accept) begin
          pack_q  <= merged;
          count_q <= fill;
        end
      end
      if (cfg_take) begin
        target_q <= cfg_target;
      end
    end
  end

  assign word_ready = !full_q;
  assign bulk_valid = valid_q;
  assign bulk_data  = out_q;
  assign bulk_count = out_count_q;
  assign busy       = (count_q != '0) || full_q || valid_q;

endmodule

// File: doc/dpu_result_packer.md
# dpu_result_packer

Downstream stage of the DPU resource. It collects the 16-bit results the DPU emits on its word output and packs them, lowest lane first, into bulk words for the register-file bulk port. A one-entry output register with a valid/ready handshake decouples the DPU result rate from the consumer. It supports a configurable words-per-bulk count and a flush that emits a partial bulk.

## Interface
Parameters:
- WORD_BITWIDTH, 16, width of one DPU result word
- BULK_BITWIDTH, 256, width of one bulk word; must be an integer multiple of WORD_BITWIDTH
- WORDS (localparam), BULK_BITWIDTH/WORD_BITWIDTH, number of lanes per bulk
- CW (localparam), $clog2(WORDS)+1, width of the count fields

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  load cfg_words
- cfg_words  in  CW  words per bulk, 1..WORDS; a value of 0 or any value greater than WORDS loads WORDS
- flush  in  1  emit the current partial bulk
- word_valid  in  1  DPU result valid
- word_data  in  WORD_BITWIDTH  DPU result
- word_ready  out  1  packer accepts a word this cycle
- bulk_valid  out  1  output register holds a bulk
- bulk_data  out  BULK_BITWIDTH  packed bulk; lane i occupies bits [i*W+W-1 : i*W]
- bulk_count  out  CW  number of valid lanes in bulk_data
- bulk_ready  in  1  consumer takes the bulk
- busy  out  1  high when count != 0, the full flag is set, or bulk_valid is high

## Operation
- The block has one clock (clk) and one reset (rst_n). Reset is asynchronous and active-low.
- State:
  - pack register (WORDS lanes)
  - lane counter `count`, range 0..WORDS-1
  - `full` flag
  - target register (reset value WORDS)
  - output register plus bulk_valid
- Handshakes:
  - Word accept: word_valid && word_ready. The word is written to lane `count`, and `count` increments.
  - Bulk drain: bulk_valid && bulk_ready.
  - `out_free` = !bulk_valid || (bulk_ready).
- Completion: when an accepted word makes count+1 == target:
  - If out_free: the output register loads the pack lanes plus the new word. Lanes at index ≥ target are forced to 0. bulk_count = target, count = 0, and all pack lanes clear.
  - Otherwise: `full` is set and the pack is held.
- While `full` is set, word_ready = 0. On the first cycle in which out_free holds, the pack transfers to the output register and `full` and `count` clear. word_ready is high again in the following cycle.
- word_ready = !full. It does not depend on word_valid.
- Flush: when flush = 1 and (count > 0 or a word is accepted in the same cycle), the pack emits as a partial bulk. bulk_count = number of lanes filled, including any word accepted that cycle, and unused lanes are 0. Flush waits for out_free in the same way as completion: it sets `full` if it is blocked. Flush with count == 0 and no accepted word is a no-op. Flush while `full` is already set is ignored.
- Config: cfg_valid takes effect only when count == 0, !full, and no word is accepted that cycle. Otherwise it is ignored, and the old target remains in force.
- No word is ever dropped or duplicated. The output register never changes while bulk_valid && !bulk_ready.

## Timing
- Reset values:
  - word_ready = 1
  - bulk_valid = 0
  - bulk_data = 0
  - bulk_count = 0
  - busy = 0
  - count = 0, full = 0, target = WORDS
- Latency: when the completing word is accepted at edge k, bulk_valid is high after edge k, i.e. 1 cycle.
- Throughput: with bulk_ready held at 1, there are no stall cycles: one word is accepted per cycle, continuously.
- Blocked completion: word_ready falls after the completing edge and rises one cycle after the draining edge.
- Simultaneous drain and completion in one cycle: the new bulk replaces the old one and bulk_valid stays high.
- Asserting rst_n low mid-bulk discards the pack and output contents immediately. All outputs return to their reset values asynchronously.

## Test plan
Bench parameters: WORD_BITWIDTH=16, BULK_BITWIDTH=64 (WORDS=4).
- Reset, then stream words 0x0001..0x0008 back-to-back with bulk_ready=1:
  - first bulk: bulk_data=0x0004_0003_0002_0001, count 4, one cycle after the 4th accept
  - second bulk: 0x0008_0007_0006_0005
  - word_ready never drops
- cfg_words=2 while idle, then send 0xAAAA, 0xBBBB → bulk_data=0x0000_0000_BBBB_AAAA, bulk_count=2.
- Send 3 words 0x0011, 0x0022, 0x0033, then flush → bulk_count=3, bulk_data=0x0000_0033_0022_0011.
  - A flush issued with count==0 produces no bulk.
- Backpressure, bulk_ready=0:
  - complete one bulk, then 4 more words → word_ready=0 after the 8th accept
  - raise bulk_ready for 1 cycle → second bulk appears and word_ready returns to 1 one cycle later
  - no word lost
- cfg_valid with cfg_words=1 issued mid-bulk (count=2) → ignored; the bulk still completes at 4 words.
- Assert rst_n low while count=3 and bulk_valid=1 → bulk_valid=0, bulk_data=0, word_ready=1 immediately; the next 4 words form a fresh bulk.
